// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared digit codes, FSM state type and digit-count helper
//
// Purpose: constants and types shared by the debug capture engine and pixel_gen.
// Ports: none (package).
package debug_pkg;

  typedef logic [4:0] dig_code_t;

  // Codes 0..15 are hex nibbles; these two are the sign glyphs.
  localparam dig_code_t DIG_BLANK = 5'd16;
  localparam dig_code_t DIG_MINUS = 5'd17;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONVERT   = 2'd1,
    WAIT_SWAP = 2'd2
  } seq_state_t;

  // One sign digit plus enough hex digits to cover the word.
  function automatic int seq_digits(input int len);
    return (len + 3) / 4 + 1;
  endfunction

endpackage

// File: rtl/debug_seq_capture_if.sv
// rtl/debug_seq_capture_if.sv - digit store read port between capture engine and pixel_gen
//
// Purpose: groups the indexed read port of the display digit bank.
// Signals: rd_ch (channel index), rd_digit (digit index), rd_code (registered digit code).
// Modports: master = reader (pixel_gen / bench), slave = capture engine.
interface debug_seq_capture_if #(
  parameter int CH_W = 1,
  parameter int DG_W = 1
);
  import debug_pkg::*;

  logic [CH_W-1:0] rd_ch;
  logic [DG_W-1:0] rd_digit;
  dig_code_t       rd_code;

  modport master (output rd_ch, output rd_digit, input rd_code);
  modport slave  (input rd_ch, input rd_digit, output rd_code);

endinterface

// File: rtl/debug_tick_gen.sv
// rtl/debug_tick_gen.sv - free-running sample-rate divider
//
// Purpose: counts 0..DIV-1 and raises tick while the count sits at DIV-1.
// Ports: sys_clk, sys_rst_n (async active-low), tick (one-cycle pulse every DIV cycles).
module debug_tick_gen #(
  parameter int DIV = 10000000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic tick
);
  import debug_pkg::*;

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  // Decoded from the counter register, so it is a clean single-cycle pulse.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/debug_seq_capture.sv
// rtl/debug_seq_capture.sv - multi-channel probe capture, hex formatting and double-buffered digit store
//
// Purpose: samples SEQ_NUM signed probe words on each tick, formats each as a sign
// digit plus hex magnitude digits (one digit per cycle) into the hidden bank, and
// swaps the displayed bank only at frame_start.
// Ports:
//   sys_clk, sys_rst_n  clock, async active-low reset
//   seq_in              packed signed probes, channel c at [c*SEQ_LEN +: SEQ_LEN]
//   freeze              blocks new sample ticks
//   frame_start         VGA frame pulse; the only point where banks swap
//   rd_if (slave)       rd_ch/rd_digit in, registered rd_code out (display bank)
//   busy                high in CONVERT and WAIT_SWAP
//   update_cnt          completed bank swaps, wraps
//   changed             per-channel change flags (only with DEBUG_SEQ_CHANGE_FLAG_EN)
// Optional feature macro: DEBUG_SEQ_CHANGE_FLAG_EN.
module debug_seq_capture
  import debug_pkg::*;
#(
  parameter int SEQ_NUM    = 4,
  parameter int SEQ_LEN    = 16,
  parameter int SAMPLE_DIV = 10000000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [SEQ_NUM*SEQ_LEN-1:0] seq_in,
  input  logic                       freeze,
  input  logic                       frame_start,
  debug_seq_capture_if.slave         rd_if,
  output logic                       busy,
  output logic [7:0]                 update_cnt
`ifdef DEBUG_SEQ_CHANGE_FLAG_EN
  ,
  output logic [SEQ_NUM-1:0]         changed
`endif
);

  localparam int SEQ_DIGITS = seq_digits(SEQ_LEN);
  localparam int CH_W       = (SEQ_NUM > 1) ? $clog2(SEQ_NUM) : 1;
  localparam int DG_W       = $clog2(SEQ_DIGITS);
  localparam int MAG_W      = 4 * (SEQ_DIGITS - 1);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(SEQ_NUM - 1);
  localparam logic [DG_W-1:0] LAST_DG = DG_W'(SEQ_DIGITS - 1);

  logic tick;
  logic new_tick;

  debug_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tick      (tick)
  );

  assign new_tick = tick && !freeze;

  seq_state_t                 state;
  logic                       pending;
  logic                       disp_bank;
  logic [CH_W-1:0]            ch;
  logic [DG_W-1:0]            dg;
  logic [SEQ_NUM*SEQ_LEN-1:0] shadow;
  dig_code_t                  bank [2][SEQ_NUM][SEQ_DIGITS];

  logic [SEQ_LEN-1:0] sh_word [SEQ_NUM];

  for (genvar c = 0; c < SEQ_NUM; c++) begin : g_unpack
    assign sh_word[c] = shadow[c*SEQ_LEN +: SEQ_LEN];
  end

  // Digit formatter for the (ch, dg) currently being written.
  logic [SEQ_LEN-1:0] cur_word;
  logic [SEQ_LEN-1:0] cur_mag;
  logic [MAG_W-1:0]   mag_ext;
  logic [3:0]         cur_nib;
  dig_code_t          cur_code;

  always_comb begin
    cur_word = sh_word[ch];
    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude.
    cur_mag  = cur_word[SEQ_LEN-1] ? (~cur_word + SEQ_LEN'(1)) : cur_word;
    mag_ext  = MAG_W'(cur_mag);
    cur_nib  = 4'(mag_ext >> (4 * (SEQ_DIGITS - 1 - int'(dg))));
    if (dg == '0) begin
      cur_code = cur_word[SEQ_LEN-1] ? DIG_MINUS : DIG_BLANK;
    end else begin
      cur_code = {1'b0, cur_nib};
    end
  end

`ifdef DEBUG_SEQ_CHANGE_FLAG_EN
  logic [SEQ_LEN-1:0] disp_word [SEQ_NUM];
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      pending    <= 1'b0;
      disp_bank  <= 1'b0;
      ch         <= '0;
      dg         <= '0;
      shadow     <= '0;
      busy       <= 1'b0;
      update_cnt <= 8'd0;
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < SEQ_NUM; c++) begin
          for (int d = 0; d < SEQ_DIGITS; d++) begin
            bank[b][c][d] <= (d == 0) ? DIG_BLANK : 5'd0;
          end
        end
      end
`ifdef DEBUG_SEQ_CHANGE_FLAG_EN
      changed <= '0;
      for (int c = 0; c < SEQ_NUM; c++) begin
        disp_word[c] <= '0;
      end
`endif
    end else begin
      case (state)
        IDLE: begin
          if (new_tick || pending) begin
            shadow  <= seq_in;
            pending <= 1'b0;
            ch      <= '0;
            dg      <= '0;
            busy    <= 1'b1;
            state   <= CONVERT;
          end
        end

        CONVERT: begin
          if (new_tick) begin
            pending <= 1'b1;
          end
          bank[~disp_bank][ch][dg] <= cur_code;
          if (dg == LAST_DG) begin
            dg <= '0;
            if (ch == LAST_CH) begin
              state <= WAIT_SWAP;
            end else begin
              ch <= ch + CH_W'(1);
            end
          end else begin
            dg <= dg + DG_W'(1);
          end
        end

        WAIT_SWAP: begin
          if (new_tick) begin
            pending <= 1'b1;
          end
          if (frame_start) begin
            disp_bank  <= ~disp_bank;
            update_cnt <= update_cnt + 8'd1;
            busy       <= 1'b0;
            state      <= IDLE;
`ifdef DEBUG_SEQ_CHANGE_FLAG_EN
            for (int c = 0; c < SEQ_NUM; c++) begin
              changed[c]   <= (sh_word[c] != disp_word[c]);
              disp_word[c] <= sh_word[c];
            end
`endif
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read port: always from the display bank, which the writer never touches.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_if.rd_code <= 5'd0;
    end else if ((int'(rd_if.rd_ch) >= SEQ_NUM) || (int'(rd_if.rd_digit) >= SEQ_DIGITS)) begin
      rd_if.rd_code <= DIG_BLANK;
    end else begin
      rd_if.rd_code <= bank[disp_bank][rd_if.rd_ch][rd_if.rd_digit];
    end
  end

endmodule

// File: tb/tb_debug_seq_capture.sv
// tb/tb_debug_seq_capture.sv - directed self-checking bench for debug_seq_capture
//
// Purpose: exercises formatting, bank swap timing, freeze, pending ticks and reset.
// Optional feature macro: DEBUG_SEQ_CHANGE_FLAG_EN (enables the change-flag checks).
module tb_debug_seq_capture;

  localparam int SEQ_NUM    = 2;
  localparam int SEQ_LEN    = 16;
  localparam int SAMPLE_DIV = 4;

  logic                       sys_clk = 1'b0;
  logic                       sys_rst_n = 1'b0;
  logic [SEQ_NUM*SEQ_LEN-1:0] seq_in = '0;
  logic                       freeze = 1'b1;
  logic                       frame_start = 1'b0;
  logic                       busy;
  logic [7:0]                 update_cnt;
`ifdef DEBUG_SEQ_CHANGE_FLAG_EN
  logic [SEQ_NUM-1:0]         changed;
`endif

  debug_seq_capture_if #(.CH_W(1), .DG_W(3)) rd_if ();

  debug_seq_capture #(
    .SEQ_NUM    (SEQ_NUM),
    .SEQ_LEN    (SEQ_LEN),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .seq_in      (seq_in),
    .freeze      (freeze),
    .frame_start (frame_start),
    .rd_if       (rd_if.slave),
    .busy        (busy),
    .update_cnt  (update_cnt)
`ifdef DEBUG_SEQ_CHANGE_FLAG_EN
    ,
    .changed     (changed)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reads all five digits of one channel, one registered read per cycle.
  task automatic read_ch(input string tag, input int ch,
                         input int e0, input int e1, input int e2, input int e3, input int e4);
    int exp [5];
    exp = '{e0, e1, e2, e3, e4};
    for (int d = 0; d < 5; d++) begin
      rd_if.rd_ch    = 1'(ch);
      rd_if.rd_digit = 3'(d);
      @(negedge sys_clk);
      check($sformatf("%s_d%0d", tag, d), int'(rd_if.rd_code), exp[d]);
    end
  endtask

  // Opens freeze until a conversion starts; returns at the negedge after busy rises.
  task automatic start_sample(input string tag, input bit keep_open);
    bit got;
    got = 1'b0;
    freeze = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (busy) begin
        got = 1'b1;
        break;
      end
    end
    if (!keep_open) freeze = 1'b1;
    check({tag, "_start"}, int'(got), 1);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge sys_clk);
    frame_start = 1'b0;
  endtask

  // Waits out a full conversion started at the current negedge, then swaps.
  task automatic finish_swap();
    repeat (11) @(negedge sys_clk);
    pulse_frame();
  endtask

  initial begin
    int errs;
    bit got;
    rd_if.rd_ch    = '0;
    rd_if.rd_digit = '0;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_rd_code", int'(rd_if.rd_code), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_update_cnt", int'(update_cnt), 0);
    sys_rst_n = 1'b1;
    read_ch("rst_ch0", 0, 16, 0, 0, 0, 0);
    read_ch("rst_ch1", 1, 16, 0, 0, 0, 0);

    // Basic conversion; frame_start on the final CONVERT cycle is ignored
    seq_in = {16'hFFFF, 16'h0123};
    start_sample("t1", 1'b0);
    seq_in = {16'h5555, 16'hAAAA};
    repeat (9) @(negedge sys_clk);
    pulse_frame();
    check("t1_fs_edge_busy", int'(busy), 1);
    check("t1_fs_edge_cnt", int'(update_cnt), 0);
    pulse_frame();
    check("t1_swap_busy", int'(busy), 0);
    check("t1_swap_cnt", int'(update_cnt), 1);
    read_ch("t1_ch0", 0, 16, 0, 1, 2, 3);
    read_ch("t1_ch1", 1, 17, 0, 0, 0, 1);

    // Most negative value and zero; out-of-range digit index
    seq_in = {16'h0000, 16'h8000};
    start_sample("t2", 1'b0);
    finish_swap();
    check("t2_cnt", int'(update_cnt), 2);
    read_ch("t2_ch0", 0, 17, 8, 0, 0, 0);
    read_ch("t2_ch1", 1, 16, 0, 0, 0, 0);
    rd_if.rd_ch = 1'b0;
    rd_if.rd_digit = 3'd5;
    @(negedge sys_clk);
    check("t2_oor_d5", int'(rd_if.rd_code), 16);
    rd_if.rd_digit = 3'd7;
    @(negedge sys_clk);
    check("t2_oor_d7", int'(rd_if.rd_code), 16);

    // Withheld frame_start: old values stay on display
    seq_in = {16'h7FFF, 16'h1234};
    start_sample("t3", 1'b0);
    rd_if.rd_ch = 1'b0;
    rd_if.rd_digit = 3'd1;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (rd_if.rd_code != 5'd8 || !busy) errs++;
    end
    check("t3_hold_errs", errs, 0);
    check("t3_hold_cnt", int'(update_cnt), 2);
    pulse_frame();
    check("t3_cnt", int'(update_cnt), 3);
    read_ch("t3_ch0", 0, 16, 1, 2, 3, 4);
    read_ch("t3_ch1", 1, 16, 7, 15, 15, 15);

    // Freeze across several ticks while inputs move
    errs = 0;
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 0) seq_in = {16'(i * 3 + 1), 16'(16'hF000 + i)};
      @(negedge sys_clk);
      if (busy) errs++;
    end
    check("t4_frozen_busy", errs, 0);
    check("t4_frozen_cnt", int'(update_cnt), 3);
    read_ch("t4_frozen_ch0", 0, 16, 1, 2, 3, 4);
    seq_in = {16'h0000, 16'hFFF0};
    start_sample("t4", 1'b0);
    finish_swap();
    check("t4_cnt", int'(update_cnt), 4);
    read_ch("t4_ch0", 0, 17, 0, 0, 1, 0);

    // Several ticks while busy leave exactly one pending conversion
    seq_in = {16'h0001, 16'h00AB};
    start_sample("t5", 1'b1);
    repeat (20) @(negedge sys_clk);
    freeze = 1'b1;
    seq_in = {16'h0002, 16'hF000};
    pulse_frame();
    check("t5_cnt1", int'(update_cnt), 5);
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      if (busy) begin
        got = 1'b1;
        break;
      end
    end
    check("t5_pending_start", int'(got), 1);
    read_ch("t5_ch0_a", 0, 16, 0, 0, 10, 11);
    repeat (6) @(negedge sys_clk);
    pulse_frame();
    check("t5_cnt2", int'(update_cnt), 6);
    read_ch("t5_ch0_b", 0, 17, 1, 0, 0, 0);
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      if (busy) errs++;
    end
    check("t5_no_second_pending", errs, 0);

    // Reset in the middle of a conversion
    seq_in = {16'h4321, 16'h8765};
    start_sample("t6", 1'b0);
    repeat (4) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_cnt", int'(update_cnt), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    read_ch("t6_ch0", 0, 16, 0, 0, 0, 0);
    read_ch("t6_ch1", 1, 16, 0, 0, 0, 0);

`ifdef DEBUG_SEQ_CHANGE_FLAG_EN
    check("t7_rst_changed", int'(changed), 0);
    seq_in = {16'h0005, 16'h0000};
    start_sample("t7", 1'b0);
    finish_swap();
    check("t7_changed", int'(changed), 2);
    read_ch("t7_ch1", 1, 16, 0, 0, 0, 5);
    start_sample("t7b", 1'b0);
    finish_swap();
    check("t7b_changed", int'(changed), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
